// File: rtl/parking_gate_fsm_pkg.sv
// Shared definitions for the parking gate controller: state codes and sensor bit positions.
package parking_gate_fsm_pkg;

    typedef enum logic [3:0] {
        StIdle       = 4'd0,
        StEntryOpen  = 4'd1,
        StEntryPass  = 4'd2,
        StExitOpen   = 4'd3,
        StExitPass   = 4'd4,
        StFullReject = 4'd5
    } state_e;

    localparam int unsigned SENS_ENTRY_REQ  = 3;
    localparam int unsigned SENS_EXIT_REQ   = 2;
    localparam int unsigned SENS_ENTRY_PASS = 1;
    localparam int unsigned SENS_EXIT_PASS  = 0;

    localparam int unsigned TIMER_WIDTH = 8;

endpackage

// File: rtl/parking_gate_fsm_gate_timer.sv
// Door-open timer: 8-bit counter with synchronous clear/enable, done at DOOR_TIMEOUT-1.
module parking_gate_fsm_gate_timer
    import parking_gate_fsm_pkg::*;
#(
    parameter int unsigned DOOR_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic done
);

    logic [TIMER_WIDTH-1:0] count_q;
    logic [TIMER_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == TIMER_WIDTH'(DOOR_TIMEOUT - 1));

endmodule

// File: rtl/parking_gate_fsm.sv
// Single-lane parking gate controller: arbitrates entry/exit gates and tracks lot occupancy.
module parking_gate_fsm
    import parking_gate_fsm_pkg::*;
#(
    parameter int unsigned CAPACITY     = 8,
    parameter int unsigned DOOR_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in,
    output logic [3:0] state,
    output logic       door_open_pulse,
    output logic [3:0] occupancy,
    output logic       full
);

    state_e     state_q, state_d;
    logic       pulse_q, pulse_d;
    logic [3:0] occ_q, occ_d;
    logic       timer_clear, timer_en, timer_done;

    parking_gate_fsm_gate_timer #(
        .DOOR_TIMEOUT(DOOR_TIMEOUT)
    ) u_gate_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .enable(timer_en),
        .done  (timer_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pulse_q <= 1'b0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            occ_q   <= occ_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in[SENS_EXIT_REQ] && (occ_q != 4'd0)) begin
                    state_d = StExitOpen;
                end else if (in[SENS_ENTRY_REQ] && !full) begin
                    state_d = StEntryOpen;
                end else if (in[SENS_ENTRY_REQ]) begin
                    state_d = StFullReject;
                end
            end
            StEntryOpen: begin
                if (in[SENS_ENTRY_PASS]) begin
                    state_d = StEntryPass;
                end else if (timer_done) begin
                    state_d = StIdle;
                end
            end
            StEntryPass:  if (!in[SENS_ENTRY_PASS]) state_d = StIdle;
            StExitOpen: begin
                if (in[SENS_EXIT_PASS]) begin
                    state_d = StExitPass;
                end else if (timer_done) begin
                    state_d = StIdle;
                end
            end
            StExitPass:   if (!in[SENS_EXIT_PASS]) state_d = StIdle;
            StFullReject: if (!in[SENS_ENTRY_REQ]) state_d = StIdle;
            default:      state_d = StIdle;
        endcase
    end

    always_comb begin
        // Open states are only reachable from idle, so this marks the first open cycle.
        pulse_d     = (state_q == StIdle) &&
                      ((state_d == StEntryOpen) || (state_d == StExitOpen));
        timer_en    = (state_q == StEntryOpen) || (state_q == StExitOpen);
        timer_clear = !timer_en;
        occ_d       = occ_q;
        if ((state_q == StEntryPass) && !in[SENS_ENTRY_PASS] && !full) begin
            occ_d = occ_q + 4'd1;
        end else if ((state_q == StExitPass) && !in[SENS_EXIT_PASS] && (occ_q != 4'd0)) begin
            occ_d = occ_q - 4'd1;
        end
    end

    assign state           = state_q;
    assign door_open_pulse = pulse_q;
    assign occupancy       = occ_q;
    assign full            = (occ_q == 4'(CAPACITY));

endmodule

// File: tb/tb_parking_gate_fsm.sv
// Directed bench for parking_gate_fsm with a behavioural lot model checked every cycle.
module tb_parking_gate_fsm;

    localparam int CAP = 8;
    localparam int DT  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in  = 4'b0000;
    logic [3:0] state;
    logic       door_open_pulse;
    logic [3:0] occupancy;
    logic       full;

    int checks = 0;
    int errors = 0;

    parking_gate_fsm #(
        .CAPACITY    (CAP),
        .DOOR_TIMEOUT(DT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in             (in),
        .state          (state),
        .door_open_pulse(door_open_pulse),
        .occupancy      (occupancy),
        .full           (full)
    );

    always #5 clk = ~clk;

    // Model: which gate is busy (0 none, 1 entry, 2 exit, 3 rejecting), whether a car is
    // in the gate, how long the gate has waited, and the car count.
    int m_gate    = 0;
    int m_passing = 0;
    int m_wait    = 0;
    int m_occ     = 0;
    int m_pulse   = 0;

    function automatic int model_code();
        if (m_gate == 1) return (m_passing != 0) ? 2 : 1;
        if (m_gate == 2) return (m_passing != 0) ? 4 : 3;
        if (m_gate == 3) return 5;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_gate = 0; m_passing = 0; m_wait = 0; m_occ = 0; m_pulse = 0;
        end else begin
            int pass_bit;
            m_pulse = 0;
            pass_bit = (m_gate == 1) ? int'(in[1]) : int'(in[0]);
            if (m_gate == 0) begin
                if (in[2] && m_occ > 0) begin
                    m_gate = 2; m_passing = 0; m_wait = 0; m_pulse = 1;
                end else if (in[3] && m_occ < CAP) begin
                    m_gate = 1; m_passing = 0; m_wait = 0; m_pulse = 1;
                end else if (in[3]) begin
                    m_gate = 3;
                end
            end else if (m_gate == 3) begin
                if (!in[3]) m_gate = 0;
            end else if (m_passing == 0) begin
                if (pass_bit != 0) m_passing = 1;
                else if (m_wait == DT - 1) m_gate = 0;
                else m_wait++;
            end else if (pass_bit == 0) begin
                if (m_gate == 1 && m_occ < CAP) m_occ++;
                if (m_gate == 2 && m_occ > 0) m_occ--;
                m_gate = 0;
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_state", int'(state), model_code());
        check("model_pulse", int'(door_open_pulse), m_pulse);
        check("model_occ", int'(occupancy), m_occ);
        check("model_full", int'(full), (m_occ == CAP) ? 1 : 0);
    end

    task automatic step(input logic [3:0] v);
        in = v;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step(4'b0000);
            check("idle_state", int'(state), 0);
            check("idle_occ", int'(occupancy), 0);
            check("idle_pulse", int'(door_open_pulse), 0);
        end

        // Normal entry
        step(4'b1000);
        check("entry_open_state", int'(state), 1);
        check("entry_open_pulse", int'(door_open_pulse), 1);
        step(4'b0010);
        check("entry_pass_state", int'(state), 2);
        check("entry_pass_pulse", int'(door_open_pulse), 0);
        step(4'b0010);
        check("entry_pass_hold", int'(state), 2);
        step(4'b0000);
        check("entry_done_state", int'(state), 0);
        check("entry_done_occ", int'(occupancy), 1);

        // Entry timeout from an empty lot, exit request ignored throughout
        do_reset();
        step(4'b1000);
        check("timeout_open", int'(state), 1);
        for (int i = 1; i < DT; i++) begin
            step(4'b0100);
            check("timeout_still_open", int'(state), 1);
        end
        step(4'b0100);
        check("timeout_closed", int'(state), 0);
        check("timeout_occ", int'(occupancy), 0);
        step(4'b0100);
        check("empty_exit_ignored", int'(state), 0);
        check("empty_exit_no_pulse", int'(door_open_pulse), 0);

        // Fill the lot
        for (int i = 0; i < CAP; i++) begin
            step(4'b1000);
            step(4'b0010);
            step(4'b0000);
        end
        check("filled_occ", int'(occupancy), 8);
        check("filled_full", int'(full), 1);
        step(4'b1000);
        check("reject_state", int'(state), 5);
        check("reject_no_pulse", int'(door_open_pulse), 0);
        step(4'b1000);
        check("reject_hold", int'(state), 5);
        step(4'b0000);
        check("reject_release", int'(state), 0);
        check("reject_occ", int'(occupancy), 8);

        // Drain to two cars
        for (int i = 0; i < 6; i++) begin
            step(4'b0100);
            step(4'b0001);
            step(4'b0000);
        end
        check("drained_occ", int'(occupancy), 2);
        check("drained_not_full", int'(full), 0);

        // Simultaneous requests: exit wins
        step(4'b1100);
        check("prio_exit_state", int'(state), 3);
        check("prio_exit_pulse", int'(door_open_pulse), 1);
        step(4'b0001);
        check("exit_pass_state", int'(state), 4);
        step(4'b0000);
        check("exit_done_state", int'(state), 0);
        check("exit_done_occ", int'(occupancy), 1);

        // Asynchronous reset mid-passage
        step(4'b1000);
        step(4'b0010);
        check("pre_reset_state", int'(state), 2);
        #1 rst = 1'b1;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_occ", int'(occupancy), 0);
        check("async_rst_pulse", int'(door_open_pulse), 0);
        @(negedge clk);
        rst = 1'b0;
        step(4'b0000);
        check("post_reset_state", int'(state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
